// File: rtl/stop_region_detector.sv
// stop_region_detector
// Counts red RGB565 pixels inside a fixed region of interest once per frame,
// confirms a red scene over several consecutive frames, and issues a single
// f2s_en request to the downstream frame-stop stage. After a request it waits
// for the stop window to end and for the scene to stay clear before re-arming.
module stop_region_detector #(
    parameter int ROI_X0         = 160,
    parameter int ROI_X1         = 479,
    parameter int ROI_Y0         = 120,
    parameter int ROI_Y1         = 359,
    parameter int R_MIN          = 20,
    parameter int G_MAX          = 20,
    parameter int B_MAX          = 12,
    parameter int PIX_THRESH     = 4000,
    parameter int CONFIRM_FRAMES = 3,
    parameter int REARM_FRAMES   = 8
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic [15:0] pixel,
    input  logic        f2s_busy,
    output logic        f2s_en,
    output logic [18:0] red_count,
    output logic        frame_hit,
    output logic        armed
);

    // Parameters narrowed once so every comparison below is width-matched.
    localparam logic [9:0]  ROI_X0_L  = ROI_X0[9:0];
    localparam logic [9:0]  ROI_X1_L  = ROI_X1[9:0];
    localparam logic [9:0]  ROI_Y0_L  = ROI_Y0[9:0];
    localparam logic [9:0]  ROI_Y1_L  = ROI_Y1[9:0];
    localparam logic [5:0]  R_MIN_L   = R_MIN[5:0];
    localparam logic [6:0]  G_MAX_L   = G_MAX[6:0];
    localparam logic [5:0]  B_MAX_L   = B_MAX[5:0];
    localparam logic [19:0] THRESH_L  = PIX_THRESH[19:0];
    localparam logic [3:0]  CONFIRM_L = CONFIRM_FRAMES[3:0];
    localparam logic [3:0]  REARM_L   = REARM_FRAMES[3:0];

    localparam logic [1:0] S_SEARCH    = 2'd0;
    localparam logic [1:0] S_FIRE      = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_REARM     = 2'd3;

    // Pixel classification
    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic        active_px;
    logic        in_roi;
    logic        is_red;
    logic        hit_d;
    logic        yen;
    logic        frame_close;
    logic [18:0] frame_sum;

    // Registered state
    logic        hit_q;
    logic        yen_q;
    logic        eval_q;
    logic [18:0] acc_q;
    logic [18:0] red_count_q;
    logic        frame_hit_q;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [3:0]  streak_q;
    logic [3:0]  streak_d;
    logic        seen_q;
    logic        seen_d;

    assign r5 = pixel[15:11];
    assign g6 = pixel[10:5];
    assign b5 = pixel[4:0];

    // The active-area gate keeps blanking pixels out even when the ROI bounds
    // reach past the visible frame.
    assign active_px   = (x_pixel < 10'd640) && (y_pixel < 10'd480);
    assign in_roi      = active_px
                      && (x_pixel >= ROI_X0_L) && (x_pixel <= ROI_X1_L)
                      && (y_pixel >= ROI_Y0_L) && (y_pixel <= ROI_Y1_L);
    assign is_red      = ({1'b0, r5} >= R_MIN_L)
                      && ({1'b0, g6} <  G_MAX_L)
                      && ({1'b0, b5} <  B_MAX_L);
    assign hit_d       = in_roi && is_red;

    // Frame ends on the first vertical-blanking cycle; yen_q resets to 0 so a
    // release during blanking cannot look like a frame end.
    assign yen         = (y_pixel < 10'd480);
    assign frame_close = !yen && yen_q;

    // The last active pixel is still sitting in hit_q at frame close.
    assign frame_sum   = acc_q + {18'd0, hit_q};

    // Pixel pipeline, per-frame accumulator and frame result registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hit_q       <= 1'b0;
            yen_q       <= 1'b0;
            eval_q      <= 1'b0;
            acc_q       <= '0;
            red_count_q <= '0;
            frame_hit_q <= 1'b0;
        end else begin
            hit_q  <= hit_d;
            yen_q  <= yen;
            eval_q <= frame_close;
            if (frame_close) begin
                red_count_q <= frame_sum;
                frame_hit_q <= ({1'b0, frame_sum} >= THRESH_L);
                acc_q       <= '0;
            end else begin
                acc_q <= frame_sum;
            end
        end
    end

    // Confirm / fire / wait-for-stop / re-arm sequencing; frame results are
    // consumed only on the eval cycle that follows a frame close.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        seen_d   = seen_q;
        case (state_q)
            S_SEARCH: begin
                if (eval_q) begin
                    if (frame_hit_q) begin
                        if (streak_q + 4'd1 == CONFIRM_L) begin
                            state_d  = S_FIRE;
                            streak_d = 4'd0;
                        end else begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else begin
                        streak_d = 4'd0;
                    end
                end
            end
            S_FIRE: begin
                state_d = S_WAIT_BUSY;
                seen_d  = 1'b0;
            end
            S_WAIT_BUSY: begin
                // Requiring a frame close covers the downstream latency
                // before busy rises.
                if (seen_q || eval_q) begin
                    seen_d = 1'b1;
                    if (!f2s_busy) begin
                        state_d  = S_REARM;
                        streak_d = 4'd0;
                        seen_d   = 1'b0;
                    end
                end
            end
            S_REARM: begin
                if (eval_q) begin
                    if (!frame_hit_q) begin
                        if (streak_q + 4'd1 == REARM_L) begin
                            state_d  = S_SEARCH;
                            streak_d = 4'd0;
                        end else begin
                            streak_d = streak_q + 4'd1;
                        end
                    end else begin
                        streak_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d  = S_SEARCH;
                streak_d = 4'd0;
                seen_d   = 1'b0;
            end
        endcase
    end

    // FSM state registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_SEARCH;
            streak_q <= 4'd0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            seen_q   <= seen_d;
        end
    end

    // FIRE lasts exactly one cycle, so the request is a single-cycle pulse.
    assign f2s_en    = (state_q == S_FIRE);
    assign armed     = (state_q == S_SEARCH);
    assign red_count = red_count_q;
    assign frame_hit = frame_hit_q;

endmodule

// File: doc/stop_region_detector.md
# stop_region_detector

Frame-rate red-region detector that sits directly upstream of the 4-second frame-stop stage on the side camera path. It classifies every RGB565 pixel inside a fixed region of interest and counts red pixels per frame. Once the count clears a threshold for CONFIRM_FRAMES consecutive frames, it issues a single-cycle f2s_en pulse. It then stays silent until the downstream stop window (f2s_busy) ends and the scene has been clear for REARM_FRAMES frames.

## Interface
- ROI_X0 / ROI_X1, default 160 / 479: inclusive horizontal ROI bounds.
- ROI_Y0 / ROI_Y1, default 120 / 359: inclusive vertical ROI bounds.
- R_MIN, default 20: red pixel requires R5 >= R_MIN.
- G_MAX, default 20: red pixel requires G6 < G_MAX.
- B_MAX, default 12: red pixel requires B5 < B_MAX.
- PIX_THRESH, default 4000: a frame is a hit when its red count >= PIX_THRESH.
- CONFIRM_FRAMES, default 3: consecutive hit frames needed to fire (1..15).
- REARM_FRAMES, default 8: consecutive non-hit frames needed to re-arm (1..15).
- pclk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- x_pixel  in  10  current column; active region is 0..639.
- y_pixel  in  10  current row; active region is 0..479.
- pixel  in  16  RGB565 value, with R=[15:11], G=[10:5], B=[4:0].
- f2s_busy  in  1  stop-window active flag from the downstream stage.
- f2s_en  out  1  one-cycle stop request.
- red_count  out  19  red count of the last completed frame.
- frame_hit  out  1  last completed frame was a hit.
- armed  out  1  FSM is in SEARCH.

## Operation
- The stage 1 register holds hit = in_roi & R5>=R_MIN & G6<G_MAX & B5<B_MAX.
  - in_roi is (x_pixel < 640) & (y_pixel < 480) & X0<=x<=X1 & Y0<=y<=Y1.
- The accumulator acc is 19 bits and adds the registered hit every cycle. It cannot overflow: the maximum count of 307200 fits in 19 bits.
- yen = y_pixel < 480; yen_d is yen registered.
- Frame close is the cycle where yen=0 and yen_d=1. On frame close:
  - red_count <= acc + hit_reg.
  - frame_hit <= (acc + hit_reg) >= PIX_THRESH.
  - acc <= 0.
  - eval <= 1 for one cycle.
- FSM states are SEARCH, FIRE, WAIT_BUSY and REARM. It acts only when eval=1, except for the FIRE exit and the WAIT_BUSY exit.
- SEARCH:
  - On a hit, streak++.
  - On a non-hit, streak <= 0.
  - When streak+1 == CONFIRM_FRAMES on a hit, go to FIRE and clear streak.
- FIRE: assert f2s_en for exactly one cycle, then go to WAIT_BUSY unconditionally.
- WAIT_BUSY:
  - Ignore frame results.
  - Leave WAIT_BUSY on the first cycle where f2s_busy=0 and at least one frame close has occurred since FIRE. The frame-close condition covers the downstream stage's latency before it raises busy.
  - On exit, go to REARM with streak <= 0.
- REARM:
  - On a non-hit, streak++.
  - On a hit, streak <= 0.
  - When streak+1 == REARM_FRAMES on a non-hit, go to SEARCH and clear streak.
- streak is 4 bits and is shared between SEARCH and REARM.
- armed = (state == SEARCH).

## Timing
- Reset values (asynchronous, active-high): f2s_en=0, red_count=0, frame_hit=0, armed=1, FSM=SEARCH, acc=0, streak=0, yen_d=0, hit_reg=0.
- Frame-close latency:
  - Let T be the first cycle with y_pixel >= 480.
  - red_count and frame_hit update at T+1 and eval=1 at T+1.
  - The FSM registers FIRE at T+2, so f2s_en is high in cycle T+2 only.
- f2s_en is never high for two consecutive cycles. At most one pulse is issued per REARM cycle.
- f2s_busy rising while in SEARCH or REARM has no effect.
- A frame close in the same cycle as the WAIT_BUSY exit is counted toward the "frame seen" condition and is not evaluated in REARM.
- Reset asserted mid-frame:
  - The partial count is discarded.
  - The first frame close after release uses a count of only the pixels seen since release.
  - Because yen_d=0 after reset, a release during vertical blanking does not produce a spurious frame close.
- Pixels with x_pixel >= 640 or y_pixel >= 480 never count, even if the ROI parameters exceed the active area.

## Test plan
- Reset, then 3 frames with the ROI fully red (pixel=16'hF800, 76800 px) -> red_count=76800 each frame; a single f2s_en pulse at T+2 of frame 3; armed=0.
- Frames alternating full red and black -> streak never reaches 3; f2s_en never asserts; frame_hit toggles 1/0.
- A frame with exactly 4000 red ROI pixels and one with 3999 -> frame_hit=1 and 0 respectively.
- After a fire, drive f2s_busy=1 for 230 frames of continuous red -> no second pulse. Busy falls, 7 black frames, then red -> still no pulse. 8 black frames, then 3 red -> second pulse.
- Red pixels placed only outside the ROI, plus pixel=F800 during blanking (x=700) -> red_count=0.
- Assert reset mid-row of frame 2 of a confirm sequence -> all outputs return to reset values immediately; streak restarts; firing requires 3 further full hit frames.
